// File: rtl/tx_fifo_store_fwd.sv
// Transmit character FIFO between the RMAP reply path and the SpaceWire transmitter.
// In store-and-forward mode only packets whose EOP/EEP is already stored are readable.
module tx_fifo_store_fwd #(
  parameter int DEPTH     = 64,
  parameter int STORE_FWD = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     writeEnable,
  input  logic [8:0]               dataIn,
  output logic                     full,
  input  logic                     readEnable,
  output logic [8:0]               dataOut,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   pktCount,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ZERO = '0;
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   pkt_q, pkt_d;
  logic [8:0]    dout_q, dout_d;
  logic          cut_q, cut_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          wr_acc, rd_acc;
  logic          wr_term, rd_term;
  logic [8:0]    rd_word;

  assign wr_acc  = writeEnable && !full_q;
  assign rd_acc  = readEnable && !empty_q;
  assign rd_word = mem[rd_ptr_q];
  assign wr_term = dataIn[8] && (dataIn[7:1] == 7'h00);
  assign rd_term = rd_word[8] && (rd_word[7:1] == 7'h00);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pkt_d    = pkt_q;
    dout_d   = dout_q;
    cut_d    = cut_q;
    full_d   = full_q;
    empty_d  = empty_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      dout_d   = rd_word;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case ({wr_acc && wr_term, rd_acc && rd_term})
      2'b10:   pkt_d = pkt_q + CNT_ONE;
      2'b01:   pkt_d = pkt_q - CNT_ONE;
      default: pkt_d = pkt_q;
    endcase

    full_d = (count_d == FULL_CNT);

    // A packet larger than the FIFO can never complete, so let it drain as in plain mode.
    if (STORE_FWD != 0) begin
      if (full_d && (pkt_d == CNT_ZERO)) cut_d = 1'b1;
      if ((rd_acc && rd_term) || (count_d == CNT_ZERO)) cut_d = 1'b0;
      empty_d = (count_d == CNT_ZERO) || ((pkt_d == CNT_ZERO) && !cut_d);
    end else begin
      cut_d   = 1'b0;
      empty_d = (count_d == CNT_ZERO);
    end

    // A paired read+write is a balanced access; it never counts as over/underflow.
    ovf_d = ovf_q || (writeEnable && full_q && !readEnable);
    unf_d = unf_q || (readEnable && empty_q && !writeEnable);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pkt_q    <= '0;
      dout_q   <= 9'h000;
      cut_q    <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pkt_q    <= pkt_d;
      dout_q   <= dout_d;
      cut_q    <= cut_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= dataIn;
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign pktCount  = pkt_q;
  assign dataOut   = dout_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_tx_fifo_store_fwd.sv
// Directed bench for tx_fifo_store_fwd: a store-and-forward instance and a plain instance.
module tb_tx_fifo_store_fwd;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       we_sf = 1'b0, re_sf = 1'b0;
  logic [8:0] din_sf = 9'h000;
  logic       full_sf, empty_sf, ovf_sf, unf_sf;
  logic [8:0] dout_sf;
  logic [6:0] cnt_sf, pkt_sf;

  logic       we_pl = 1'b0, re_pl = 1'b0;
  logic [8:0] din_pl = 9'h000;
  logic       full_pl, empty_pl, ovf_pl, unf_pl;
  logic [8:0] dout_pl;
  logic [6:0] cnt_pl, pkt_pl;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tx_fifo_store_fwd #(.DEPTH(64), .STORE_FWD(1)) dut_sf (
    .clk(clk), .reset(reset),
    .writeEnable(we_sf), .dataIn(din_sf), .full(full_sf),
    .readEnable(re_sf), .dataOut(dout_sf), .empty(empty_sf),
    .count(cnt_sf), .pktCount(pkt_sf),
    .overflow(ovf_sf), .underflow(unf_sf)
  );

  tx_fifo_store_fwd #(.DEPTH(64), .STORE_FWD(0)) dut_pl (
    .clk(clk), .reset(reset),
    .writeEnable(we_pl), .dataIn(din_pl), .full(full_pl),
    .readEnable(re_pl), .dataOut(dout_pl), .empty(empty_pl),
    .count(cnt_pl), .pktCount(pkt_pl),
    .overflow(ovf_pl), .underflow(unf_pl)
  );

  typedef struct {
    logic       we;
    logic [8:0] din;
    logic       re;
    logic [8:0] dout;
    logic       empty;
    logic       full;
    logic [6:0] cnt;
    logic [6:0] pkt;
    logic       unf;
  } vec_t;

  vec_t vecs [14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkSf(input string name, input logic e_empty, input logic e_full,
                         input logic [6:0] e_cnt, input logic [6:0] e_pkt);
    checkOutput({name, ".empty"}, 32'(empty_sf), 32'(e_empty));
    checkOutput({name, ".full"},  32'(full_sf),  32'(e_full));
    checkOutput({name, ".count"}, 32'(cnt_sf),   32'(e_cnt));
    checkOutput({name, ".pkt"},   32'(pkt_sf),   32'(e_pkt));
  endtask

  // Drive one cycle of stimulus on the store-and-forward instance, sample 1 time unit after the edge.
  task automatic applyStimulus(input logic we, input logic [8:0] din, input logic re);
    we_sf  = we;
    din_sf = din;
    re_sf  = re;
    @(posedge clk);
    #1;
    we_sf  = 1'b0;
    re_sf  = 1'b0;
  endtask

  task automatic applyPlain(input logic we, input logic [8:0] din, input logic re);
    we_pl  = we;
    din_pl = din;
    re_pl  = re;
    @(posedge clk);
    #1;
    we_pl  = 1'b0;
    re_pl  = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 9'h011, 1'b0, 9'h000, 1'b1, 1'b0, 7'd1, 7'd0, 1'b0};
    vecs[1]  = '{1'b1, 9'h022, 1'b0, 9'h000, 1'b1, 1'b0, 7'd2, 7'd0, 1'b0};
    vecs[2]  = '{1'b1, 9'h033, 1'b0, 9'h000, 1'b1, 1'b0, 7'd3, 7'd0, 1'b0};
    vecs[3]  = '{1'b1, 9'h100, 1'b0, 9'h000, 1'b0, 1'b0, 7'd4, 7'd1, 1'b0};
    vecs[4]  = '{1'b0, 9'h000, 1'b1, 9'h011, 1'b0, 1'b0, 7'd3, 7'd1, 1'b0};
    vecs[5]  = '{1'b0, 9'h000, 1'b1, 9'h022, 1'b0, 1'b0, 7'd2, 7'd1, 1'b0};
    vecs[6]  = '{1'b0, 9'h000, 1'b1, 9'h033, 1'b0, 1'b0, 7'd1, 7'd1, 1'b0};
    vecs[7]  = '{1'b0, 9'h000, 1'b1, 9'h100, 1'b1, 1'b0, 7'd0, 7'd0, 1'b0};
    vecs[8]  = '{1'b0, 9'h000, 1'b1, 9'h100, 1'b1, 1'b0, 7'd0, 7'd0, 1'b1};
    vecs[9]  = '{1'b0, 9'h000, 1'b0, 9'h100, 1'b1, 1'b0, 7'd0, 7'd0, 1'b1};
    vecs[10] = '{1'b1, 9'h102, 1'b0, 9'h100, 1'b1, 1'b0, 7'd1, 7'd0, 1'b1};
    vecs[11] = '{1'b1, 9'h101, 1'b0, 9'h100, 1'b0, 1'b0, 7'd2, 7'd1, 1'b1};
    vecs[12] = '{1'b0, 9'h000, 1'b1, 9'h102, 1'b0, 1'b0, 7'd1, 7'd1, 1'b1};
    vecs[13] = '{1'b0, 9'h000, 1'b1, 9'h101, 1'b1, 1'b0, 7'd0, 7'd0, 1'b1};

    @(posedge clk);
    #1;
    doReset();
    checkSf("reset", 1'b1, 1'b0, 7'd0, 7'd0);
    checkOutput("reset.dout", 32'(dout_sf), 32'h000);
    checkOutput("reset.ovf",  32'(ovf_sf),  32'd0);
    checkOutput("reset.unf",  32'(unf_sf),  32'd0);

    $display("[TB] packet release table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].we, vecs[i].din, vecs[i].re);
      checkSf($sformatf("vec%0d", i), vecs[i].empty, vecs[i].full, vecs[i].cnt, vecs[i].pkt);
      checkOutput($sformatf("vec%0d.dout", i), 32'(dout_sf), 32'(vecs[i].dout));
      checkOutput($sformatf("vec%0d.unf", i),  32'(unf_sf),  32'(vecs[i].unf));
    end

    $display("[TB] plain mode");
    doReset();
    applyPlain(1'b1, 9'h0A5, 1'b0);
    checkOutput("plain.empty_after_wr", 32'(empty_pl), 32'd0);
    checkOutput("plain.count_after_wr", 32'(cnt_pl),   32'd1);
    applyPlain(1'b0, 9'h000, 1'b1);
    checkOutput("plain.dout",  32'(dout_pl),  32'h0A5);
    checkOutput("plain.count", 32'(cnt_pl),   32'd0);
    checkOutput("plain.empty", 32'(empty_pl), 32'd1);

    $display("[TB] oversize packet fill and drain");
    doReset();
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 9'(i + 64), 1'b0);
      checkOutput($sformatf("fill%0d.count", i), 32'(cnt_sf),   32'(i + 1));
      checkOutput($sformatf("fill%0d.empty", i), 32'(empty_sf), (i == 63) ? 32'd0 : 32'd1);
    end
    checkOutput("fill.full", 32'(full_sf), 32'd1);
    applyStimulus(1'b1, 9'h0EE, 1'b0);
    checkOutput("extra_wr.ovf",   32'(ovf_sf), 32'd1);
    checkOutput("extra_wr.count", 32'(cnt_sf), 32'd64);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b0, 9'h000, 1'b1);
      checkOutput($sformatf("drain%0d.dout", i), 32'(dout_sf), 32'(i + 64));
    end
    checkSf("drained", 1'b1, 1'b0, 7'd0, 7'd0);
    applyStimulus(1'b1, 9'h0AA, 1'b0);
    checkOutput("wrap_partial.empty", 32'(empty_sf), 32'd1);
    applyStimulus(1'b1, 9'h100, 1'b0);
    checkOutput("wrap_pkt.empty", 32'(empty_sf), 32'd0);
    applyStimulus(1'b0, 9'h000, 1'b1);
    checkOutput("wrap_rd0", 32'(dout_sf), 32'h0AA);
    applyStimulus(1'b0, 9'h000, 1'b1);
    checkOutput("wrap_rd1", 32'(dout_sf), 32'h100);
    checkSf("wrap_done", 1'b1, 1'b0, 7'd0, 7'd0);

    $display("[TB] simultaneous access at full and empty");
    doReset();
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 9'(i + 64), 1'b0);
    applyStimulus(1'b1, 9'h0FF, 1'b1);
    checkSf("rw_full", 1'b0, 1'b0, 7'd63, 7'd0);
    checkOutput("rw_full.dout", 32'(dout_sf), 32'h040);
    checkOutput("rw_full.ovf",  32'(ovf_sf),  32'd0);
    doReset();
    applyStimulus(1'b1, 9'h0AB, 1'b1);
    checkSf("rw_empty", 1'b1, 1'b0, 7'd1, 7'd0);
    checkOutput("rw_empty.unf",  32'(unf_sf),  32'd0);
    checkOutput("rw_empty.dout", 32'(dout_sf), 32'h000);

    $display("[TB] terminator read and write in the same cycle");
    doReset();
    applyStimulus(1'b1, 9'h0D1, 1'b0);
    applyStimulus(1'b1, 9'h101, 1'b0);
    applyStimulus(1'b1, 9'h0E1, 1'b0);
    applyStimulus(1'b0, 9'h000, 1'b1);
    checkOutput("pkt_a.rd0", 32'(dout_sf), 32'h0D1);
    applyStimulus(1'b1, 9'h100, 1'b1);
    checkOutput("pkt_ab.dout", 32'(dout_sf), 32'h101);
    checkSf("pkt_ab", 1'b0, 1'b0, 7'd2, 7'd1);
    applyStimulus(1'b0, 9'h000, 1'b1);
    checkOutput("pkt_b.rd0", 32'(dout_sf), 32'h0E1);
    applyStimulus(1'b0, 9'h000, 1'b1);
    checkOutput("pkt_b.rd1", 32'(dout_sf), 32'h100);
    checkSf("pkt_b_done", 1'b1, 1'b0, 7'd0, 7'd0);

    $display("[TB] asynchronous reset mid-packet");
    doReset();
    applyStimulus(1'b1, 9'h0A1, 1'b0);
    applyStimulus(1'b1, 9'h0A2, 1'b0);
    applyStimulus(1'b1, 9'h100, 1'b0);
    applyStimulus(1'b1, 9'h0B1, 1'b0);
    applyStimulus(1'b1, 9'h0B2, 1'b0);
    applyStimulus(1'b1, 9'h0B3, 1'b0);
    applyStimulus(1'b1, 9'h101, 1'b0);
    applyStimulus(1'b1, 9'h0C1, 1'b0);
    applyStimulus(1'b1, 9'h0C2, 1'b0);
    applyStimulus(1'b1, 9'h0C3, 1'b0);
    applyStimulus(1'b1, 9'h0C4, 1'b0);
    applyStimulus(1'b0, 9'h000, 1'b1);
    checkSf("pre_reset", 1'b0, 1'b0, 7'd10, 7'd2);
    checkOutput("pre_reset.dout", 32'(dout_sf), 32'h0A1);
    reset = 1'b1;
    #2;
    checkSf("async_reset", 1'b1, 1'b0, 7'd0, 7'd0);
    checkOutput("async_reset.dout", 32'(dout_sf), 32'h000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b1, 9'h0F1, 1'b0);
    checkSf("post_reset_wr0", 1'b1, 1'b0, 7'd1, 7'd0);
    applyStimulus(1'b1, 9'h100, 1'b0);
    checkSf("post_reset_wr1", 1'b0, 1'b0, 7'd2, 7'd1);
    applyStimulus(1'b0, 9'h000, 1'b1);
    checkOutput("post_reset_rd0", 32'(dout_sf), 32'h0F1);
    applyStimulus(1'b0, 9'h000, 1'b1);
    checkOutput("post_reset_rd1", 32'(dout_sf), 32'h100);
    checkSf("post_reset_done", 1'b1, 1'b0, 7'd0, 7'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
